ppu_write_buffer: RTL and testbench

Vertical-blank write buffer between the Avalon-MM host port and the PPU table-write port. Host writes to the attribute, sprite and color tables are queued in a FIFO instead of reaching the PPU mid-frame. They are replayed to the PPU one per cycle, only while the raster is in vertical blank. This prevents tearing and half-updated sprites. A status register reports queue occupancy and overflow.

---
 rtl/ppu_pkg.sv | 22 ++
 rtl/ppu_write_buffer_if.sv | 21 ++
 rtl/ppu_write_buffer_wb_fifo.sv | 64 ++++++
 rtl/ppu_write_buffer.sv | 157 +++++++++++++++
 tb/tb_ppu_write_buffer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: raster timing, host address map and write-buffer types.
package ppu_pkg;

    localparam int VACTIVE = 480;
    localparam int VTOTAL  = 525;

    localparam logic [15:0] ATTR_BASE   = 16'h0000;
    localparam logic [15:0] SPRITE_BASE = 16'h0100;
    localparam logic [15:0] COLOR_BASE  = 16'h0200;
    localparam logic [15:0] CTRL_COMMIT = 16'h8000;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/ppu_write_buffer_if.sv
// Avalon-MM host port of the write buffer: master is the host, slave is the buffer.
interface ppu_write_buffer_if;

    logic        chipselect;
    logic        write;
    logic        read;
    logic [15:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );

endinterface

// File: rtl/ppu_write_buffer_wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t with exposed pointers and occupancy.
// Latency: a push is visible on rd_data/count the next cycle; rd_data is the head, combinational.
// Backpressure: a push while full is dropped, a pop while empty is ignored; simultaneous push/pop keep count.
module wb_fifo
    import ppu_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push,
    input  wb_entry_t        push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output wb_entry_t        rd_data
);

    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL = {1'b1, {PTR_W{1'b0}}};

    wb_entry_t mem [DEPTH];
    logic      do_push;
    logic      do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    // Full is judged on the registered count, so a same-cycle pop never admits a push.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ppu_write_buffer.sv
// ppu_write_buffer: queues host table writes, replays them to the PPU one per cycle during vertical blank; PPU_WB_COMMIT_EN limits draining to committed batches.
// Latency: an eligible entry pushed in cycle T is on ppu_write in T+2; status readdata is valid the cycle after the read.
// Backpressure: none from the PPU; host pushes into a full queue are dropped and set the sticky overflow flag.
module ppu_write_buffer #(
    parameter int DEPTH   = 16,
    parameter int VACTIVE = ppu_pkg::VACTIVE
) (
    input  logic                clk,
    input  logic                reset_n,
    ppu_write_buffer_if.slave   host,
    input  logic [9:0]          vcount,
    output logic                ppu_chipselect,
    output logic                ppu_write,
    output logic [15:0]         ppu_address,
    output logic [31:0]         ppu_writedata
);

    import ppu_pkg::*;

    localparam int         PTR_W       = $clog2(DEPTH);
    localparam logic [9:0] VBLANK_LINE = 10'(VACTIVE);

    wb_state_t        state;
    wb_state_t        state_n;
    wb_entry_t        push_data;
    wb_entry_t        rd_data;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             commit_wr;
    logic             status_rd;
    logic             overflow;
    logic             vblank;
    logic             eligible;
    logic             commit_valid;

    assign vblank    = (vcount >= VBLANK_LINE);
    assign push      = host.chipselect & host.write & ~host.address[15];
    assign commit_wr = host.chipselect & host.write & (host.address == CTRL_COMMIT);
    assign status_rd = host.chipselect & host.read & host.address[15];
    assign push_data = {host.address, host.writedata};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .clr_n     (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .rd_data   (rd_data)
    );

`ifdef PPU_WB_COMMIT_EN
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0] commit_ptr;
    logic [PTR_W-1:0] commit_ptr_n;
    logic             commit_valid_n;

    // A commit that lands while its last entry is being popped must not leave a stale batch open.
    always_comb begin
        commit_ptr_n   = commit_ptr;
        commit_valid_n = commit_valid;
        if (commit_wr && !empty) begin
            commit_ptr_n   = wr_ptr;
            commit_valid_n = 1'b1;
        end
        if (pop && ((rd_ptr + PTR_ONE) == commit_ptr_n)) begin
            commit_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_ptr   <= '0;
            commit_valid <= 1'b0;
        end else begin
            commit_ptr   <= commit_ptr_n;
            commit_valid <= commit_valid_n;
        end
    end

    assign eligible = commit_valid & ~empty;
`else
    logic unused_commit;

    assign commit_valid  = 1'b0;
    assign eligible      = ~empty;
    assign unused_commit = ^{commit_wr, wr_ptr, rd_ptr};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Popping in the cycle IDLE decides to drain keeps the push-to-strobe latency at two cycles.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (vblank && eligible) begin
                    pop     = 1'b1;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (vblank && eligible) begin
                    pop = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ppu_chipselect <= 1'b0;
            ppu_write      <= 1'b0;
            ppu_address    <= '0;
            ppu_writedata  <= '0;
        end else begin
            ppu_chipselect <= pop;
            ppu_write      <= pop;
            ppu_address    <= pop ? rd_data.addr : '0;
            ppu_writedata  <= pop ? rd_data.data : '0;
        end
    end

    // A read reports the flag as it stood and clears it; a simultaneous drop re-arms it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow      <= 1'b0;
            host.readdata <= '0;
        end else begin
            overflow <= (overflow & ~status_rd) | (push & full);
            if (status_rd) begin
                host.readdata <= {20'b0, overflow, vblank, commit_valid, 9'(count)};
            end
        end
    end

endmodule

// File: tb/tb_ppu_write_buffer.sv
// Directed bench for ppu_write_buffer: queue-based reference model checked every cycle plus literal spot checks.
module tb_ppu_write_buffer;

    localparam int DEPTH = 16;
`ifdef PPU_WB_COMMIT_EN
    localparam logic [31:0] CVB   = 32'h0000_0200;
    localparam logic [31:0] T4_RD = 32'h0000_0402;
`else
    localparam logic [31:0] CVB   = 32'h0000_0000;
    localparam logic [31:0] T4_RD = 32'h0000_0400;
`endif

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  vcount  = '0;
    logic        ppu_chipselect;
    logic        ppu_write;
    logic [15:0] ppu_address;
    logic [31:0] ppu_writedata;

    int n_vec = 0;
    int n_bad = 0;

    ppu_write_buffer_if host();

    ppu_write_buffer #(.DEPTH(DEPTH), .VACTIVE(480)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .host           (host),
        .vcount         (vcount),
        .ppu_chipselect (ppu_chipselect),
        .ppu_write      (ppu_write),
        .ppu_address    (ppu_address),
        .ppu_writedata  (ppu_writedata)
    );

    always #5 clk = ~clk;

    // Reference model: pending entries as a queue, expected registered outputs.
    logic [47:0] mq[$];
    logic        m_ov;
    logic        m_cv;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_data;
    logic [31:0] m_rd;
`ifdef PPU_WB_COMMIT_EN
    int          m_celig;
`endif

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov   = 1'b0;
        m_cv   = 1'b0;
        m_wr   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_rd   = '0;
`ifdef PPU_WB_COMMIT_EN
        m_celig = 0;
`endif
    endtask

    task automatic model_step();
        logic [47:0] e;
        logic        vb;
        logic        is_push;
        logic        is_rd;
        logic        is_full;
        logic        do_pop;
        int          start;
        int          elig;
        if (!reset_n) begin
            model_reset();
            return;
        end
        vb      = (vcount >= 10'd480);
        start   = mq.size();
        is_full = (start == DEPTH);
        is_push = host.chipselect && host.write && !host.address[15];
        is_rd   = host.chipselect && host.read && host.address[15];
`ifdef PPU_WB_COMMIT_EN
        elig = m_celig;
`else
        elig = start;
`endif
        do_pop = vb && (elig > 0);
        if (is_rd) m_rd = {20'b0, m_ov, vb, m_cv, 9'(start)};
        m_wr = do_pop;
        if (do_pop) begin
            e      = mq.pop_front();
            m_addr = e[47:32];
            m_data = e[31:0];
        end
`ifdef PPU_WB_COMMIT_EN
        if (host.chipselect && host.write && host.address == 16'h8000 && start > 0) m_celig = start;
        if (do_pop) m_celig--;
        m_cv = (m_celig > 0);
`endif
        m_ov = (m_ov && !is_rd) || (is_push && is_full);
        if (is_push && !is_full) mq.push_back({host.address, host.writedata});
    endtask

    initial forever begin
        @(negedge clk);
        chk("ppu_write", 48'(ppu_write), 48'(m_wr));
        chk("ppu_chipselect", 48'(ppu_chipselect), 48'(m_wr));
        if (m_wr) begin
            chk("ppu_address", 48'(ppu_address), 48'(m_addr));
            chk("ppu_writedata", 48'(ppu_writedata), 48'(m_data));
        end
        chk("readdata", 48'(host.readdata), 48'(m_rd));
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_idle();
        host.chipselect = 1'b0;
        host.write      = 1'b0;
        host.read       = 1'b0;
        host.address    = '0;
        host.writedata  = '0;
    endtask

    task automatic host_write(input logic [15:0] a, input logic [31:0] d);
        host.chipselect = 1'b1;
        host.write      = 1'b1;
        host.read       = 1'b0;
        host.address    = a;
        host.writedata  = d;
        tick();
        bus_idle();
    endtask

    task automatic status_read();
        host.chipselect = 1'b1;
        host.write      = 1'b0;
        host.read       = 1'b1;
        host.address    = 16'h8000;
        tick();
        bus_idle();
    endtask

    initial begin
        bus_idle();
        model_reset();
        idle(2);
        chk("reset ppu_write", 48'(ppu_write), 48'(0));
        chk("reset ppu_address", 48'(ppu_address), 48'(0));
        chk("reset readdata", 48'(host.readdata), 48'(0));
        reset_n = 1'b1;
        vcount  = 10'd100;
        idle(1);

        // Single write held until vblank
        host_write(16'h0005, 32'hDEAD_BEEF);
        host_write(16'h8000, 32'h0);
        idle(3);
        vcount = 10'd480;
        tick();
        chk("t1 write", 48'(ppu_write), 48'(1));
        chk("t1 addr", 48'(ppu_address), 48'(16'h0005));
        chk("t1 data", 48'(ppu_writedata), 48'(32'hDEAD_BEEF));
        tick();
        chk("t1 strobe", 48'(ppu_write), 48'(0));
        status_read();
        chk("t1 status", 48'(host.readdata), 48'(32'h0000_0400));

        // Push-to-strobe latency in vblank with an empty queue
        host_write(16'h0105, 32'h1234_5678);
`ifdef PPU_WB_COMMIT_EN
        host_write(16'h8000, 32'h0);
`endif
        chk("lat T+1", 48'(ppu_write), 48'(0));
        tick();
        chk("lat T+2", 48'(ppu_write), 48'(1));
        chk("lat addr", 48'(ppu_address), 48'(16'h0105));
        tick();
        vcount = 10'd100;

        // Overflow: 17 pushes into 16 entries
        for (int i = 0; i < 17; i++) host_write(16'(16'h0100 + i), 32'hA000_0000 + 32'(i));
        host_write(16'h8000, 32'h0);
        status_read();
        chk("t2 ovf read", 48'(host.readdata), 48'(32'h0000_0810 | CVB));
        status_read();
        chk("t2 ovf clear", 48'(host.readdata), 48'(32'h0000_0010 | CVB));
        vcount = 10'd480;
        idle(20);
        status_read();
        chk("t2 drained", 48'(host.readdata), 48'(32'h0000_0400));
        vcount = 10'd100;

        // Drain interrupted by vcount wrap after four pops
        for (int i = 0; i < 10; i++) host_write(16'(16'h0200 + i), 32'hC000_0000 + 32'(i));
        host_write(16'h8000, 32'h0);
        vcount = 10'd524;
        idle(4);
        vcount = 10'd0;
        idle(5);
        status_read();
        chk("t3 held", 48'(host.readdata), 48'(32'h0000_0006 | CVB));
        vcount = 10'd480;
        idle(10);
        vcount = 10'd100;

        // Commit batches; a non-commit control write is ignored
        for (int i = 0; i < 3; i++) host_write(16'(16'h0010 + i), 32'hB000_0000 + 32'(i));
        host_write(16'h8000, 32'h0);
        status_read();
        chk("t4 committed", 48'(host.readdata), 48'(32'h0000_0003 | CVB));
        for (int i = 0; i < 2; i++) host_write(16'(16'h0020 + i), 32'hB100_0000 + 32'(i));
        host_write(16'h8004, 32'h0);
        vcount = 10'd480;
        idle(8);
        status_read();
        chk("t4 remain", 48'(host.readdata), 48'(T4_RD));
        host_write(16'h8000, 32'h0);
        idle(4);
        vcount = 10'd100;

        // Push every cycle while draining
        for (int i = 0; i < 4; i++) host_write(16'(16'h0300 + i), 32'hE000_0000 + 32'(i));
        host_write(16'h8000, 32'h0);
        vcount = 10'd480;
        for (int i = 0; i < 8; i++) host_write(16'(16'h0310 + i), 32'hE100_0000 + 32'(i));
        status_read();
`ifndef PPU_WB_COMMIT_EN
        chk("t5 steady", 48'(host.readdata), 48'(32'h0000_0404));
`endif
        host_write(16'h8000, 32'h0);
        idle(14);
        vcount = 10'd100;

        // Reset in the middle of a drain
        for (int i = 0; i < 6; i++) host_write(16'(16'h0400 + i), 32'hF000_0000 + 32'(i));
        host_write(16'h8000, 32'h0);
        vcount = 10'd480;
        idle(2);
        chk("t6 draining", 48'(ppu_write), 48'(1));
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t6 async write", 48'(ppu_write), 48'(0));
        chk("t6 async cs", 48'(ppu_chipselect), 48'(0));
        idle(2);
        reset_n = 1'b1;
        vcount  = 10'd100;
        status_read();
        chk("t6 empty", 48'(host.readdata), 48'(32'h0000_0000));
        vcount = 10'd480;
        idle(6);
        status_read();
        chk("t6 no writes", 48'(host.readdata), 48'(32'h0000_0400));
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
